// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the DM/bridge (slave).
interface dm_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store sequencer: decodes MIPS memory opcodes onto a req/ack data-memory bus,
// stalls the pipeline until the access retires, and flags misalignment and bus timeout.
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_c_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        exc_bus_o,
  dm_access_ctrl_if.master mem
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

  state_e              state_q;
  logic                store_q;
  logic                unsigned_q;
  logic [1:0]          size_q;
  logic [1:0]          lane_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                exc_adel_q;
  logic                exc_ades_q;
  logic                exc_bus_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                legal_c;
  logic                store_c;
  logic [1:0]          size_c;
  logic                misalign_c;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wdata_lane_c;
  logic [7:0]          byte_sel_c;
  logic [15:0]         half_sel_c;
  logic [DATA_W-1:0]   load_ext_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // Opcode decode of the incoming request: legality, alignment, lanes.
  always_comb begin
    store_c      = op_i[3];
    size_c       = op_i[1:0];
    legal_c      = (op_i == OP_LB)  || (op_i == OP_LH)  || (op_i == OP_LW) ||
                   (op_i == OP_LBU) || (op_i == OP_LHU) || (op_i == OP_SB) ||
                   (op_i == OP_SH)  || (op_i == OP_SW);
    misalign_c   = 1'b0;
    be_c         = 4'b1111;
    wdata_lane_c = '0;
    case (size_c)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: misalign_c = addr_i[0];
      default: misalign_c = |addr_i[1:0];
    endcase
    if (store_c) begin
      case (size_c)
        SZ_BYTE: begin
          be_c         = 4'b0001 << addr_i[1:0];
          wdata_lane_c = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          be_c         = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_lane_c = {2{wdata_i[15:0]}};
        end
        default: begin
          be_c         = 4'b1111;
          wdata_lane_c = wdata_i;
        end
      endcase
    end
  end

  // Lane select and extension of the returned word using the latched access.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel_c = mem.mem_rdata[7:0];
      2'd1:    byte_sel_c = mem.mem_rdata[15:8];
      2'd2:    byte_sel_c = mem.mem_rdata[23:16];
      default: byte_sel_c = mem.mem_rdata[31:24];
    endcase
    half_sel_c = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext_c = unsigned_q ? {24'd0, byte_sel_c}
                                       : {{24{byte_sel_c[7]}}, byte_sel_c};
      SZ_HALF: load_ext_c = unsigned_q ? {16'd0, half_sel_c}
                                       : {{16{half_sel_c[15]}}, half_sel_c};
      default: load_ext_c = mem.mem_rdata;
    endcase
    if (store_q) load_ext_c = '0;
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Stall is live in the request cycle so the MEM stage holds on acceptance.
  assign stall_c_o = ((state_q == ST_IDLE) && req_valid_i && legal_c) || (state_q == ST_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      store_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      exc_adel_q  <= 1'b0;
      exc_ades_q  <= 1'b0;
      exc_bus_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && legal_c) begin
            store_q    <= store_c;
            unsigned_q <= op_i[2];
            size_q     <= size_c;
            lane_q     <= addr_i[1:0];
            rdata_q    <= '0;
            if (misalign_c) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              exc_adel_q <= !store_c;
              exc_ades_q <= store_c;
            end else begin
              state_q     <= ST_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= store_c;
              mem_be_q    <= be_c;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wdata_q <= wdata_lane_c;
            end
          end
        end
        ST_REQ: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem.mem_ack || (cnt_inc_c == CNT_W'(TIMEOUT))) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            rdata_q     <= mem.mem_ack ? load_ext_c : '0;
            exc_bus_q   <= !mem.mem_ack;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          rdata_q    <= '0;
          exc_adel_q <= 1'b0;
          exc_ades_q <= 1'b0;
          exc_bus_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign exc_adel_o    = exc_adel_q;
  assign exc_ades_o    = exc_ades_q;
  assign exc_bus_o     = exc_bus_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: directed accesses push expected bus and retire results,
// independent monitors compare them against the bus and the done pulse.
module tb_dm_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  op_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_bus;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .op_i        (op_in),
    .addr_i      (addr_in),
    .wdata_i     (wdata_in),
    .stall_c_o   (stall),
    .done_o      (done),
    .rdata_o     (rdata),
    .exc_adel_o  (exc_adel),
    .exc_ades_o  (exc_ades),
    .exc_bus_o   (exc_bus),
    .mem         (bus)
  );

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  typedef struct packed {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        bus;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_len;
    logic [7:0]  len;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int ack_wait_cfg = -1;
  logic [31:0] mrdata_cfg = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: acks after ack_wait_cfg extra cycles of mem_req, never if negative.
  initial begin
    int req_cyc;
    req_cyc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (req_cyc == ack_wait_cfg) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mrdata_cfg;
        end
        req_cyc++;
      end else begin
        req_cyc = 0;
      end
    end
  end

  // Bus monitor: checks request attributes on the first cycle and the request length.
  initial begin
    bit   in_req;
    int   len;
    bus_t e;
    in_req = 0;
    len    = 0;
    e      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_req = 0;
      end else if (bus.mem_req === 1'b1 && !in_req) begin
        in_req = 1;
        len    = 1;
        if (bus_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
          e = '0;
        end else begin
          e = bus_q.pop_front();
          chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, e.we});
          chk("mem_be",    {28'd0, bus.mem_be}, {28'd0, e.be});
          chk("mem_addr",  bus.mem_addr, e.addr);
          chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
      end else if (bus.mem_req === 1'b1) begin
        len++;
      end else if (in_req) begin
        in_req = 0;
        if (e.chk_len) chk("mem_req_cycles", 32'(len), {24'd0, e.len});
      end
    end
  end

  // Retire monitor: every done pulse is matched against the oldest expected result.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && done === 1'b1) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          chk("rdata",    rdata, r.rdata);
          chk("exc_adel", {31'd0, exc_adel}, {31'd0, r.adel});
          chk("exc_ades", {31'd0, exc_ades}, {31'd0, r.ades});
          chk("exc_bus",  {31'd0, exc_bus},  {31'd0, r.bus});
          chk("stall_in_done", {31'd0, stall}, 32'd0);
        end
      end
    end
  end

  // Issue one access from a negedge; returns at the negedge of its done cycle.
  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input int ackw, input logic [31:0] mrd,
                     input logic [31:0] erd, input logic eadel, input logic eades,
                     input logic ebus, input logic [3:0] ebe, input logic [31:0] ewd,
                     input int ereq, input int elat);
    int   n;
    int   w;
    bit   seen;
    res_t r;
    bus_t b;
    r.rdata = erd; r.adel = eadel; r.ades = eades; r.bus = ebus;
    res_q.push_back(r);
    if (ereq > 0) begin
      b.we = op[3]; b.be = ebe; b.addr = {a[31:2], 2'b00}; b.wdata = ewd;
      b.chk_len = 1'b1; b.len = 8'(ereq);
      bus_q.push_back(b);
    end
    ack_wait_cfg = ackw;
    mrdata_cfg   = mrd;
    req_valid = 1'b1; op_in = op; addr_in = a; wdata_in = wd;
    #1;
    w = 0;
    while (stall !== 1'b1 && w < 4) begin
      @(negedge clk); #1; w++;
    end
    chk("stall_on_request", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; op_in = SW; addr_in = 32'hFFFF_FFFF; wdata_in = 32'hFFFF_FFFF;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (done === 1'b1) seen = 1;
      else if (stall !== 1'b1) chk("stall_while_busy", {31'd0, stall}, 32'd1);
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    else chk("latency", 32'(n + 1), 32'(elat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; op_in = '0; addr_in = '0; wdata_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_stall",   {31'd0, stall}, 32'd0);
    chk("reset_done",    {31'd0, done}, 32'd0);
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_mem_be",  {28'd0, bus.mem_be}, 32'd0);
    chk("reset_rdata",   rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //   op   addr          wdata         ackw mrdata        exp rdata    adel ades bus  be       mem_wdata     req lat
    run(SB,  32'h0000_1003, 32'h0000_00AB, 1, 32'h0,        32'h0,        0, 0, 0, 4'b1000, 32'hABAB_ABAB, 2,  4);
    run(LH,  32'h0000_2002, 32'h0,         0, 32'h8001_1234, 32'hFFFF_8001, 0, 0, 0, 4'b1111, 32'h0,        1,  3);
    run(LHU, 32'h0000_2002, 32'h0,         0, 32'h8001_1234, 32'h0000_8001, 0, 0, 0, 4'b1111, 32'h0,        1,  3);
    run(LW,  32'h0000_3001, 32'h0,        -1, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,         0,  2);
    run(SH,  32'h0000_3001, 32'h0000_BEEF,-1, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,         0,  2);
    run(LH,  32'h0000_3003, 32'h0,        -1, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,         0,  2);
    run(SW,  32'h0000_4000, 32'hDEAD_BEEF,-1, 32'h0,        32'h0,        0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 16, 18);
    run(SW,  32'h0000_4004, 32'h1357_9BDF,15, 32'h0,        32'h0,        0, 0, 0, 4'b1111, 32'h1357_9BDF, 16, 18);
    run(LB,  32'h0000_5001, 32'h0,         0, 32'h1122_F344, 32'hFFFF_FFF3, 0, 0, 0, 4'b1111, 32'h0,        1,  3);
    run(SB,  32'h0000_5002, 32'h1234_5678, 2, 32'h0,        32'h0,        0, 0, 0, 4'b0100, 32'h7878_7878, 3,  5);
    run(LBU, 32'h0000_5003, 32'h0,         0, 32'h9A00_0000, 32'h0000_009A, 0, 0, 0, 4'b1111, 32'h0,        1,  3);
    run(SH,  32'h0000_6002, 32'h0000_CAFE, 0, 32'h0,        32'h0,        0, 0, 0, 4'b1100, 32'hCAFE_CAFE, 1,  3);
    run(LW,  32'h0000_7000, 32'h0,         1, 32'h89AB_CDEF, 32'h89AB_CDEF, 0, 0, 0, 4'b1111, 32'h0,        2,  4);

    // Illegal opcode: no stall, no bus cycle, no retire.
    @(negedge clk);
    req_valid = 1'b1; op_in = 6'b001000; addr_in = 32'h0000_9000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illegal_stall",   {31'd0, stall}, 32'd0);
      chk("illegal_mem_req", {31'd0, bus.mem_req}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;

    // Reset during REQ aborts the access with no done pulse.
    begin
      bus_t b;
      b.we = 1'b1; b.be = 4'b1111; b.addr = 32'h0000_A000; b.wdata = 32'h0BAD_F00D;
      b.chk_len = 1'b0; b.len = 8'd0;
      bus_q.push_back(b);
      ack_wait_cfg = -1;
      req_valid = 1'b1; op_in = SW; addr_in = 32'h0000_A000; wdata_in = 32'h0BAD_F00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_req_before", {31'd0, bus.mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("abort_mem_we",  {31'd0, bus.mem_we}, 32'd0);
      chk("abort_mem_be",  {28'd0, bus.mem_be}, 32'd0);
      chk("abort_stall",   {31'd0, stall}, 32'd0);
      chk("abort_done",    {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
    run(LHU, 32'h0000_8000, 32'h0, 0, 32'h0000_FFFE, 32'h0000_FFFE, 0, 0, 0, 4'b1111, 32'h0, 1, 3);

    repeat (4) @(negedge clk);
    chk("res_queue_empty", 32'(res_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
